power_stream: RTL and testbench
===============================

POWER_STREAM -- requirements
Module: power_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which sets the signed width of the FFT real and imaginary inputs.
REQ-002 SHALL have parameter PWR_SHIFT, default 0, which sets the right shift applied to each power sum before output.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_fft_valid, input, 1 bit: an FFT sample is present this cycle. There is no backpressure.
REQ-006 SHALL have port i_fft_sop, input, 1 bit: start of frame. Meaningful only when i_fft_valid=1, and marks bin 0.
REQ-007 SHALL have port i_fft_re, input, DATA_W bits, signed: real part of the bin.
REQ-008 SHALL have port i_fft_im, input, DATA_W bits, signed: imaginary part of the bin.
REQ-009 SHALL have port o_cnt, output, 11 bits: frame slot counter for the harmonic-product stage.
REQ-010 SHALL have port o_square_add, output, 32 bits, unsigned: bin power aligned to o_cnt.
REQ-011 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse.
REQ-012 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse.

Function
REQ-013 SHALL compute power as re*re + im*im through a 2-stage pipeline: stage 1 registers the inputs, stage 2 multiplies and adds. Valid and sop travel with the data.
REQ-014 SHALL compute the sum at 2*DATA_W+1 bits, shift it right by PWR_SHIFT, and saturate it to 32 bits.
REQ-015 SHALL take every state decision from the stage-2 output (valid, sop, power).
REQ-016 SHALL implement states IDLE, FEED and POST.
REQ-017 In IDLE: o_cnt=2047 and o_square_add=0. Stage-2 valid samples without sop are discarded.
REQ-018 IDLE to FEED: on a stage-2 valid sample with sop, in the same cycle output o_cnt=0 and o_square_add=power.
REQ-019 In FEED: each stage-2 valid sample is output with o_cnt = previous o_cnt + 1 and o_square_add = power.
REQ-020 In FEED, on a cycle with no stage-2 valid sample: o_cnt holds and o_square_add=0.
REQ-021 FEED to POST: on the cycle after bin 1023 is output.
REQ-022 In POST: o_cnt increments by 1 every cycle from 1024 to 2047, o_square_add=0, and all input samples are discarded.
REQ-023 POST to IDLE: when o_cnt reaches 2047. o_frame_done=1 in that cycle.
REQ-024 Early sop in FEED (stage-2 valid sample with sop): o_cnt=2047, o_square_add=0, o_frame_err=1, next state IDLE, and that sample is dropped.
REQ-025 A stage-2 valid sample with sop in POST SHALL pulse o_frame_err, with no state change.
REQ-026 o_cnt SHALL never take any value other than 2047 between bin 1023 of one frame and bin 0 of the next.
REQ-027 Every frame the harmonic-product stage sees SHALL be bins 0..1023 followed by slots 1024..2047.

Reset
REQ-028 While i_rst=1: state=IDLE, o_cnt=2047, o_square_add=0, o_frame_done=0, o_frame_err=0, and all pipeline valid bits=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame. The first output after reset is o_cnt=2047.
REQ-030 Samples present during reset or in its release cycle SHALL never reach stage 2.

Configuration
REQ-031 When macro POWER_STREAM_DC_BLOCK_EN is defined: the power of bin 0 (o_cnt=0) SHALL be output as 0, while still advancing the count.
REQ-032 When POWER_STREAM_DC_BLOCK_EN is undefined: bin 0 power SHALL be output unmodified.

Verification
REQ-033 Contiguous frame: sop sample re=3, im=4, then 1023 samples re=1, im=0.
- o_cnt=0 with o_square_add=25 two cycles after the sop input.
- o_cnt 1..1023 with o_square_add=1 each.
- o_cnt 1024..2047 with o_square_add=0.
- o_frame_done=1 at o_cnt=2047.
REQ-034 Gapped input: valid low for 3 cycles after bin 5.
- o_cnt holds 5 with o_square_add=0 for 3 cycles, then resumes at 6.
REQ-035 Extremes with DATA_W=16: re=-32768, im=-32768.
- o_square_add=2147483648, no overflow.
- With PWR_SHIFT=4: 134217728.
REQ-036 Early sop at bin 500:
- o_cnt=2047 and o_frame_err=1 in that cycle.
- The next sop restarts at o_cnt=0.
REQ-037 Sop in POST and reset mid-FEED:
- Sop in POST gives o_frame_err=1 with the o_cnt sequence unbroken.
- i_rst=1 at bin 300 gives o_cnt=2047 the next cycle with no residual valid output.
REQ-038 With POWER_STREAM_DC_BLOCK_EN defined: sop sample re=3, im=4 gives o_cnt=0 with o_square_add=0.

Source files
------------

// File: rtl/power_stream.sv
`default_nettype none
// ============================================================================
// Module      : power_stream
// Description : Turns a stream of FFT bins into per-bin power
//               (re*re + im*im) and frames it for a harmonic-product stage.
//               Each frame on the output is bins 0..1023 followed by empty
//               slots 1024..2047. Between frames the slot counter is held
//               at 2047.
//
//               Pipeline : stage 1 registers the inputs. Stage 2 computes the
//                          power and registers it. Valid and sop travel with
//                          the data. All framing decisions are taken from the
//                          stage-2 registers, so the power of a sample appears
//                          on the outputs two clocks after it is presented.
//
// Parameters  : DATA_W    - signed width of i_fft_re / i_fft_im
//               PWR_SHIFT - right shift applied to the (2*DATA_W+1)-bit sum
//                           before it is saturated to 32 bits
//
// Ports       : i_clk        - clock, rising edge
//               i_rst        - synchronous active-high reset
//               i_fft_valid  - sample present this cycle (no backpressure)
//               i_fft_sop    - start of frame, marks bin 0 (qualified by valid)
//               i_fft_re     - signed real part of the bin
//               i_fft_im     - signed imaginary part of the bin
//               o_cnt        - frame slot counter (2047 when idle)
//               o_square_add - bin power aligned to o_cnt, 0 in empty slots
//               o_frame_done - one-cycle pulse on the last slot (2047)
//               o_frame_err  - one-cycle pulse on an unexpected sop
//
// Options     : POWER_STREAM_DC_BLOCK_EN - when defined, the power of bin 0
//               is output as 0. The count still advances normally.
//
// Revision    : 1.0 - initial release
// ============================================================================
module power_stream #(
  parameter int DATA_W    = 16,
  parameter int PWR_SHIFT = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_fft_valid,
  input  logic                     i_fft_sop,
  input  logic signed [DATA_W-1:0] i_fft_re,
  input  logic signed [DATA_W-1:0] i_fft_im,
  output logic [10:0]              o_cnt,
  output logic [31:0]              o_square_add,
  output logic                     o_frame_done,
  output logic                     o_frame_err
);

  localparam int SUM_W = 2 * DATA_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FEED = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;

  localparam logic [10:0] c_cnt_idle     = 11'd2047;
  localparam logic [10:0] c_cnt_pre_last = 11'd1022;  // bin before bin 1023
  localparam logic [10:0] c_cnt_pre_end  = 11'd2046;  // slot before slot 2047

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // rel_q is high in the cycle right after reset is released. A sample
  // presented in that cycle is kept out of the pipeline.
  logic                     rel_q,      rel_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_sop_q,   s1_sop_d;
  logic signed [DATA_W-1:0] s1_re_q,    s1_re_d;
  logic signed [DATA_W-1:0] s1_im_q,    s1_im_d;
  logic                     s2_valid_q, s2_valid_d;
  logic                     s2_sop_q,   s2_sop_d;
  logic [31:0]              s2_pwr_q,   s2_pwr_d;
  logic [1:0]               state_q,    state_d;
  logic [10:0]              cnt_q,      cnt_d;

  // --------------------------------------------------------------------------
  // Stage 1: register the inputs
  // --------------------------------------------------------------------------
  always_comb begin
    rel_d      = 1'b0;
    s1_valid_d = i_fft_valid & ~rel_q;
    s1_sop_d   = i_fft_valid & i_fft_sop;
    s1_re_d    = i_fft_re;
    s1_im_d    = i_fft_im;
  end

  // --------------------------------------------------------------------------
  // Stage 2: square, add, shift, saturate
  // --------------------------------------------------------------------------
  logic signed [2*DATA_W-1:0] re_ext;
  logic signed [2*DATA_W-1:0] im_ext;
  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;
  logic [SUM_W-1:0]           pwr_sum;
  logic [SUM_W-1:0]           pwr_sh;
  logic [31:0]                pwr_sat;

  always_comb begin
    re_ext  = {{DATA_W{s1_re_q[DATA_W-1]}}, s1_re_q};
    im_ext  = {{DATA_W{s1_im_q[DATA_W-1]}}, s1_im_q};
    re_sq   = re_ext * re_ext;
    im_sq   = im_ext * im_ext;
    // A square of a signed value is never negative, so the MSB of each
    // product is zero and both can be zero-extended into the sum.
    pwr_sum = {1'b0, re_sq} + {1'b0, im_sq};
    pwr_sh  = pwr_sum >> PWR_SHIFT;
  end

  generate
    if (SUM_W > 32) begin : g_sat
      assign pwr_sat = (|pwr_sh[SUM_W-1:32]) ? 32'hFFFF_FFFF : pwr_sh[31:0];
    end else begin : g_nosat
      assign pwr_sat = {{(32 - SUM_W){1'b0}}, pwr_sh};
    end
  endgenerate

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sop_d   = s1_sop_q;
    s2_pwr_d   = pwr_sat;
  end

  // --------------------------------------------------------------------------
  // State and pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rel_q      <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_pwr_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= c_cnt_idle;
    end else begin
      rel_q      <= rel_d;
      s1_valid_q <= s1_valid_d;
      s1_sop_q   <= s1_sop_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s2_valid_q <= s2_valid_d;
      s2_sop_q   <= s2_sop_d;
      s2_pwr_q   <= s2_pwr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s2_valid_q && s2_sop_q) begin
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (s2_valid_q) begin
          if (s2_sop_q) begin
            state_d = ST_IDLE;
          end else if (cnt_q == c_cnt_pre_last) begin
            // bin 1023 goes out this cycle, the padding slots start next
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (cnt_q == c_cnt_pre_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // The outputs come straight from this logic, so a frame's slot value and
  // its power appear in the same cycle the stage-2 sample is consumed.
  // cnt_q keeps the slot shown in the previous cycle, so the slot can hold
  // across input gaps.
  logic [31:0] sq_w;
  logic        done_w;
  logic        err_w;

  always_comb begin
    cnt_d  = cnt_q;
    sq_w   = 32'd0;
    done_w = 1'b0;
    err_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = c_cnt_idle;
        if (s2_valid_q && s2_sop_q) begin
          cnt_d = 11'd0;
`ifdef POWER_STREAM_DC_BLOCK_EN
          sq_w  = 32'd0;
`else
          sq_w  = s2_pwr_q;
`endif
        end
      end
      ST_FEED: begin
        if (s2_valid_q) begin
          if (s2_sop_q) begin
            // A sop in the middle of a frame abandons the frame and drops
            // the sample. The next sop starts a clean frame.
            cnt_d = c_cnt_idle;
            err_w = 1'b1;
          end else begin
            cnt_d = cnt_q + 11'd1;
            sq_w  = s2_pwr_q;
          end
        end
      end
      ST_POST: begin
        cnt_d  = cnt_q + 11'd1;
        done_w = (cnt_d == c_cnt_idle);
        err_w  = s2_valid_q & s2_sop_q;
      end
      default: cnt_d = c_cnt_idle;
    endcase

    // While reset is high the outputs show the idle values, whatever the
    // registers held before.
    if (i_rst) begin
      cnt_d  = c_cnt_idle;
      sq_w   = 32'd0;
      done_w = 1'b0;
      err_w  = 1'b0;
    end
  end

  assign o_cnt        = cnt_d;
  assign o_square_add = sq_w;
  assign o_frame_done = done_w;
  assign o_frame_err  = err_w;

endmodule
`default_nettype wire

// File: tb/tb_power_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_stream
// Description : Directed self-checking bench for power_stream. Covers reset,
//               full frames, input gaps, input extremes (with a second
//               instance at PWR_SHIFT=4), an early sop, a sop during the
//               padding slots and a reset in the middle of a frame.
//               Honours POWER_STREAM_DC_BLOCK_EN for the expected bin 0 power.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_stream;

`ifdef POWER_STREAM_DC_BLOCK_EN
  localparam logic [31:0] c_exp_bin0 = 32'd0;
`else
  localparam logic [31:0] c_exp_bin0 = 32'd25;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               fft_valid;
  logic               fft_sop;
  logic signed [15:0] fft_re;
  logic signed [15:0] fft_im;

  logic [10:0] o_cnt;
  logic [31:0] o_square_add;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [10:0] sh_cnt;
  logic [31:0] sh_sq;
  logic        sh_done;
  logic        sh_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  power_stream #(.DATA_W(16), .PWR_SHIFT(0)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fft_valid  (fft_valid),
    .i_fft_sop    (fft_sop),
    .i_fft_re     (fft_re),
    .i_fft_im     (fft_im),
    .o_cnt        (o_cnt),
    .o_square_add (o_square_add),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  power_stream #(.DATA_W(16), .PWR_SHIFT(4)) dut_sh (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fft_valid  (fft_valid),
    .i_fft_sop    (fft_sop),
    .i_fft_re     (fft_re),
    .i_fft_im     (fft_im),
    .o_cnt        (sh_cnt),
    .o_square_add (sh_sq),
    .o_frame_done (sh_done),
    .o_frame_err  (sh_err)
  );

  // Drive one cycle of input, then step to 1 time unit past the clock edge
  // where the outputs are stable. After a call, the outputs show the sample
  // driven by the previous call.
  task automatic cyc(input logic v, input logic s,
                     input logic signed [15:0] re, input logic signed [15:0] im);
    fft_valid = v;
    fft_sop   = s;
    fft_re    = re;
    fft_im    = im;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
      total++;
      if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=0",
                 i, o_cnt, o_square_add, o_frame_done, o_frame_err);
      end
    end
    // a sop is also presented in the release cycle and must be ignored
    rst = 1'b0;
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
      total++;
      if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=0",
                 i, o_cnt, o_square_add, o_frame_done, o_frame_err);
      end
    end
  endtask

  // Full frame: sop (3,4) then 1023 samples (1,0). Samples keep flowing
  // through the padding slots. A sop is driven so that it reaches the output
  // at slot post_sop_at (-1 means no sop in the padding slots).
  task automatic test_frame(input int post_sop_at);
    do_reset();
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    total++;
    if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL frame_pre got cnt=%0d sq=%0d want cnt=2047 sq=0", o_cnt, o_square_add);
    end
    for (int j = 1; j <= 1024; j++) begin
      cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
      total++;
      if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !==
          {11'(j - 1), (j == 1) ? c_exp_bin0 : 32'd1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL frame_bin bin=%0d got cnt=%0d sq=%0d done=%b err=%b want cnt=%0d sq=%0d",
                 j - 1, o_cnt, o_square_add, o_frame_done, o_frame_err, j - 1,
                 (j == 1) ? c_exp_bin0 : 32'd1);
      end
    end
    for (int k = 1024; k <= 2047; k++) begin
      cyc(1'b1, (k + 1 == post_sop_at), 16'sd1, 16'sd0);
      total++;
      if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !==
          {11'(k), 32'd0, (k == 2047), (k == post_sop_at)}) begin
        bad++;
        $display("FAIL frame_post slot=%0d got cnt=%0d sq=%0d done=%b err=%b want cnt=%0d sq=0 done=%b err=%b",
                 k, o_cnt, o_square_add, o_frame_done, o_frame_err, k,
                 (k == 2047), (k == post_sop_at));
      end
    end
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    total++;
    if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL frame_after got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=0",
               o_cnt, o_square_add, o_frame_done, o_frame_err);
    end
  endtask

  task automatic test_gap();
    logic [10:0] e_cnt [0:4];
    logic [31:0] e_sq  [0:4];
    e_cnt = '{11'd5, 11'd5, 11'd5, 11'd5, 11'd6};
    e_sq  = '{32'd4, 32'd0, 32'd0, 32'd0, 32'd4};
    do_reset();
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b0, 16'sd2, 16'sd0);
      total++;
      if ({o_cnt, o_square_add} !== {11'(j - 1), (j == 1) ? c_exp_bin0 : 32'd4}) begin
        bad++;
        $display("FAIL gap_bin bin=%0d got cnt=%0d sq=%0d want cnt=%0d sq=%0d",
                 j - 1, o_cnt, o_square_add, j - 1, (j == 1) ? c_exp_bin0 : 32'd4);
      end
    end
    // three idle input cycles, then bins 6 and 7
    for (int i = 0; i < 5; i++) begin
      cyc((i >= 3), 1'b0, 16'sd2, 16'sd0);
      total++;
      if ({o_cnt, o_square_add, o_frame_err} !== {e_cnt[i], e_sq[i], 1'b0}) begin
        bad++;
        $display("FAIL gap_hold step=%0d got cnt=%0d sq=%0d err=%b want cnt=%0d sq=%0d err=0",
                 i, o_cnt, o_square_add, o_frame_err, e_cnt[i], e_sq[i]);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    cyc(1'b1, 1'b1, 16'sd0, 16'sd0);
    cyc(1'b1, 1'b0, -16'sd32768, -16'sd32768);
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    total++;
    if ({o_cnt, o_square_add} !== {11'd1, 32'd2147483648}) begin
      bad++;
      $display("FAIL extreme_shift0 got cnt=%0d sq=%0d want cnt=1 sq=2147483648", o_cnt, o_square_add);
    end
    total++;
    if ({sh_cnt, sh_sq} !== {11'd1, 32'd134217728}) begin
      bad++;
      $display("FAIL extreme_shift4 got cnt=%0d sq=%0d want cnt=1 sq=134217728", sh_cnt, sh_sq);
    end
  endtask

  task automatic test_early_sop();
    do_reset();
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    for (int j = 1; j <= 499; j++) cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    total++;
    if ({o_cnt, o_square_add, o_frame_err} !== {11'd499, 32'd1, 1'b0}) begin
      bad++;
      $display("FAIL early_prev got cnt=%0d sq=%0d err=%b want cnt=499 sq=1 err=0",
               o_cnt, o_square_add, o_frame_err);
    end
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    total++;
    if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL early_err got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=1",
               o_cnt, o_square_add, o_frame_done, o_frame_err);
    end
    cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
    total++;
    if ({o_cnt, o_square_add, o_frame_err} !== {11'd2047, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL early_idle got cnt=%0d sq=%0d err=%b want cnt=2047 sq=0 err=0",
               o_cnt, o_square_add, o_frame_err);
    end
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    total++;
    if ({o_cnt, o_square_add, o_frame_err} !== {11'd0, c_exp_bin0, 1'b0}) begin
      bad++;
      $display("FAIL early_restart got cnt=%0d sq=%0d err=%b want cnt=0 sq=%0d err=0",
               o_cnt, o_square_add, o_frame_err, c_exp_bin0);
    end
  endtask

  task automatic test_reset_mid_feed();
    do_reset();
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    for (int j = 1; j <= 301; j++) cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
    total++;
    if ({o_cnt, o_square_add} !== {11'd300, 32'd1}) begin
      bad++;
      $display("FAIL midrst_bin got cnt=%0d sq=%0d want cnt=300 sq=1", o_cnt, o_square_add);
    end
    rst = 1'b1;
    cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
    total++;
    if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_assert got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=0",
               o_cnt, o_square_add, o_frame_done, o_frame_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'sd1, 16'sd0);
      total++;
      if ({o_cnt, o_square_add, o_frame_done, o_frame_err} !== {11'd2047, 32'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL midrst_after cyc=%0d got cnt=%0d sq=%0d done=%b err=%b want cnt=2047 sq=0 done=0 err=0",
                 i, o_cnt, o_square_add, o_frame_done, o_frame_err);
      end
    end
    cyc(1'b1, 1'b1, 16'sd3, 16'sd4);
    cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
    total++;
    if ({o_cnt, o_square_add} !== {11'd0, c_exp_bin0}) begin
      bad++;
      $display("FAIL midrst_restart got cnt=%0d sq=%0d want cnt=0 sq=%0d", o_cnt, o_square_add, c_exp_bin0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_re    = '0;
    fft_im    = '0;
    test_reset();
    test_frame(-1);
    test_frame(1100);
    test_gap();
    test_extremes();
    test_early_sop();
    test_reset_mid_feed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
